ram16k: RTL and testbench
=========================

// Module: ram16k
// PURPOSE
//  Single-port synchronous RAM: 16384 words x 16 bit, one shared read/write address.
//  Serves as the 16K data/program memory of the HDL computer datapath.
//  Write is synchronous. Read has one cycle of latency through a registered q output.
// PARAMETERS
//  ADDR_W  14            address width; DEPTH = 2**ADDR_W words (16384)
//  DATA_W  16            word width
// PORTS
//  clock    in   1       single clock; all state updates on rising edge
//  aclr     in   1       synchronous, active-high reset (sampled on rising clock edge)
//  address  in   ADDR_W  word address for both read and write
//  data     in   DATA_W  write data
//  wren     in   1       write enable, active-high
//  q        out  DATA_W  registered read data
// BEHAVIOUR
//  - One clock (clock). Reset aclr is synchronous and active-high; no asynchronous paths.
//  - Storage: mem[0:DEPTH-1] of DATA_W bits. Power-up contents undefined (X in simulation).
//    Users must write a word before reading it.
//  - Rising edge with aclr=1: q <= 0.
//    Memory contents are preserved.
//    wren is ignored; no write occurs while aclr=1.
//    aclr has priority over all other inputs.
//  - Rising edge with aclr=0 and wren=1:
//    mem[address] <= data;
//    q <= data (write-first / new-data read-during-write).
//  - Rising edge with aclr=0 and wren=0: q <= mem[address].
//  - Read latency: 1 cycle.
//    Address presented before edge N gives its data on q after edge N, held until edge N+1.
//    q is stable between edges.
//  - q depends only on registered state. There is no combinational path from address or data to q.
//  - Address range is the full 0..DEPTH-1, so no out-of-range handling is needed.
//    Addresses 0 and 16383 must both be usable.
//  - Back-to-back writes to consecutive addresses, one per cycle, are supported. There are no stall cycles.
//  - Back-to-back reads are supported at one word per cycle.
//  - The block is synthesisable and written so the tool infers block RAM.
//  - The output register on q is the only resettable state.
// TESTING
//  - Zero fill: wren=1, write 16'h0000 to addresses 0..16383 (one per cycle).
//    Then wren=0 and read all 16384 words -> every read returns 16'h0000.
//  - Ones fill: write 16'hFFFF to all addresses, then read all -> every read returns 16'hFFFF.
//    This shows no stuck-at-0 bits.
//  - Address pattern: write data=i to address i for i=0..16383.
//    Then set address=i and sample after the next rising edge -> q==i for every i.
//    This covers decode uniqueness and the 1-cycle latency.
//  - Read-during-write: mem[5]=16'h1234; write 16'hABCD to address 5 with wren=1.
//    -> q==16'hABCD after that edge; a later read of address 5 returns 16'hABCD.
//  - Reset: with q!=0, assert aclr=1 for one edge while wren=1, address=7, data=16'h5555.
//    -> q==0 after that edge; mem[7] keeps its prior value on a later read.
//  - Boundaries: write 16'h0001 at address 0 and 16'h8000 at address 16383.
//    -> the reads return those exact values, and address 1 and address 16382 are unchanged.
//  - The bench counts passes and errors and reports totals. A pass requires zero errors.

Source files
------------

// File: rtl/ram16k.sv
`default_nettype none
// ============================================================================
//  Module      : ram16k
//  Description : Single-port synchronous RAM, 2**ADDR_W x DATA_W (16K x 16).
//                Shared read/write address, write-first, registered q output
//                with one cycle of read latency. Only q is resettable.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram16k #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q
);

  localparam int C_DEPTH = 2 ** ADDR_W;

  // Storage array; no reset so the tool can map it onto block RAM.
  logic [DATA_W-1:0] r_mem [0:C_DEPTH-1];

  // Write is gated by reset because aclr has priority over wren.
  logic w_we;
  assign w_we = wren & ~aclr;

  // Memory write port: contents are preserved across reset.
  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[address] <= data;
    end
  end

  // Registered read port: write-first on a write, otherwise the stored word.
  always_ff @(posedge clock) begin
    if (aclr) begin
      q <= '0;
    end else if (wren) begin
      q <= data;
    end else begin
      q <= r_mem[address];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram16k.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram16k
//  Description : Directed self-checking bench for ram16k.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram16k;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clock = 1'b0;
  logic              aclr  = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [DATA_W-1:0] data = '0;
  logic              wren = 1'b0;
  logic [DATA_W-1:0] q;

  int n_checks = 0;
  int n_fail   = 0;

  ram16k #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock   (clock),
    .aclr    (aclr),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q)
  );

  // 10 ns clock period.
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int idx, input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (q === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: q=%h expected %h", tag, idx, q, exp);
    end
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d);
    aclr = 1'b0; wren = 1'b1; address = ADDR_W'(a); data = d;
    tick();
  endtask

  task automatic rd(input int a);
    aclr = 1'b0; wren = 1'b0; address = ADDR_W'(a); data = 16'hDEAD;
    tick();
  endtask

  initial begin
    // Reset state of q.
    aclr = 1'b1; wren = 1'b0;
    tick();
    check("reset_q", 0, 16'h0000);

    // Zero fill over a strided subset of the address space.
    for (int i = 0; i < DEPTH; i += 8) wr(i, 16'h0000);
    for (int i = 0; i < DEPTH; i += 8) begin
      rd(i);
      check("zero_fill", i, 16'h0000);
    end

    // Ones fill over the whole array.
    for (int i = 0; i < DEPTH; i++) wr(i, 16'hFFFF);
    for (int i = 0; i < DEPTH; i++) begin
      rd(i);
      check("ones_fill", i, 16'hFFFF);
    end

    // Address pattern: mem[i] = i, read back with one cycle latency.
    for (int i = 0; i < DEPTH; i++) wr(i, DATA_W'(i));
    for (int i = 0; i < DEPTH; i++) begin
      rd(i);
      check("addr_pat", i, DATA_W'(i));
    end

    // Boundaries: extremes written, neighbours keep the address pattern.
    wr(0, 16'h0001);
    check("wr_first_q", 0, 16'h0001);
    wr(DEPTH-1, 16'h8000);
    check("wr_last_q", DEPTH-1, 16'h8000);
    rd(0);        check("bound_lo", 0, 16'h0001);
    rd(DEPTH-1);  check("bound_hi", DEPTH-1, 16'h8000);
    rd(1);        check("bound_lo_nbr", 1, 16'h0001);
    rd(DEPTH-2);  check("bound_hi_nbr", DEPTH-2, 16'h3FFE);

    // Read-during-write returns the new data.
    wr(5, 16'h1234);
    check("rdw_init", 5, 16'h1234);
    rd(5);        check("rdw_pre", 5, 16'h1234);
    wr(5, 16'hABCD);
    check("rdw_new", 5, 16'hABCD);
    rd(4);        check("rdw_other", 4, 16'h0004);
    rd(5);        check("rdw_read", 5, 16'hABCD);

    // Reset with wren asserted: q clears, no write happens.
    wr(7, 16'h7777);
    check("rst_pre", 7, 16'h7777);
    aclr = 1'b1; wren = 1'b1; address = ADDR_W'(7); data = 16'h5555;
    tick();
    check("rst_q", 7, 16'h0000);
    rd(7);        check("rst_mem", 7, 16'h7777);

    // q holds between edges while inputs change mid-cycle.
    address = ADDR_W'(9); data = 16'h0F0F; wren = 1'b1;
    #3;
    check("hold_q", 7, 16'h7777);
    tick();
    check("hold_wr", 9, 16'h0F0F);
    rd(9);        check("hold_rd", 9, 16'h0F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
